cheri_branch_resolve_pipe: RTL
==============================

Name: cheri_branch_resolve_pipe

Overview:
- Pipelined, parametrised successor to the single-cycle combinational branch resolver.
- Computes branch/jump targets, checks the target and the current PCC (bounds, tag, seal, execute permission, alignment), and queues resolutions in a DEPTH-entry FIFO toward the frontend/scoreboard.
- Valid/ready handshake on both sides, so several branches can be in flight.
- Sits between the issue stage and frontend PC generation.

Parameters:
VLEN, 39, virtual address width
DEPTH, 4, resolution FIFO entries (power of two, >=2)
TRANS_ID_BITS, 3, scoreboard transaction id width
RVC, 1, compressed ISA enabled (1: 2-byte alignment; 0: 4-byte alignment)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
flush_i  in  1  synchronous pipeline and FIFO flush
valid_i  in  1  request valid
ready_o  out  1  request accepted when valid_i && ready_o
op_i  in  2  0=BRANCH, 1=JAL, 2=JALR, 3=CJALR
trans_id_i  in  TRANS_ID_BITS  scoreboard id
pc_i  in  VLEN  instruction address
pcc_base_i  in  VLEN  PCC base
pcc_top_i  in  VLEN+1  PCC top (exclusive)
is_compressed_i  in  1  2-byte instruction
imm_i  in  VLEN  sign-extended offset
cmp_res_i  in  1  ALU compare result (BRANCH only)
opa_addr_i  in  VLEN  rs1 address (JALR/CJALR)
opa_base_i  in  VLEN  rs1 capability base (CJALR)
opa_top_i  in  VLEN+1  rs1 capability top (CJALR)
opa_tag_i  in  1  rs1 tag
opa_perm_x_i  in  1  rs1 execute permission
opa_sealed_i  in  1  rs1 sealed
opa_sentry_i  in  1  rs1 otype is sentry
pred_taken_i  in  1  frontend predicted taken
pred_target_i  in  VLEN  predicted target
res_valid_o  out  1  FIFO head valid
res_ready_i  in  1  consumer pops head
res_trans_id_o  out  TRANS_ID_BITS  head id
res_pc_o  out  VLEN  head instruction pc
res_target_o  out  VLEN  resolved next fetch address
res_link_o  out  VLEN  pc + 2/4 (link value)
res_taken_o  out  1  jump or taken branch
res_mispredict_o  out  1  prediction wrong
res_ex_cause_o  out  3  0=none, 1=misaligned, 2=target length, 3=perm_x, 4=seal, 5=tag, 6=PCC length
count_o  out  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (async, rst_ni low): all stage valids cleared; FIFO pointers and count_o = 0; res_valid_o = 0; all res_* data outputs = 0.
- Stage S1 (registered on accept):
  - base = opa_addr_i for JALR/CJALR, else pc_i.
  - target = base + imm_i, modulo 2^VLEN, signed add.
  - Bit 0 of target cleared for JALR/CJALR.
  - link = pc_i + (is_compressed_i ? 2 : 4).
  - taken = 1 for JAL/JALR/CJALR; cmp_res_i for BRANCH.
- Stage S2 (registered):
  - res_target = taken ? target : link.
  - Mispredict:
    - BRANCH: taken != pred_taken_i.
    - Jumps: !pred_taken_i || target != pred_target_i.
  - Exception checks; highest priority wins:
    - PCC length (6): pc < pcc_base || pc >= pcc_top. Checked for every op.
    - CJALR only:
      - tag (5): !opa_tag.
      - seal (4): opa_sealed && (!opa_sentry || imm != 0).
      - perm_x (3): !opa_perm_x.
    - Target length (2): CJALR && taken && (target < opa_base || target + 2 > opa_top). Computed in VLEN+1 bits.
    - Misaligned (1): taken && (target[0] || (!RVC && target[1])).
  - A not-taken branch never raises 1 or 2.
  - An excepting entry has res_mispredict = 0.
- Latency: a request accepted at edge N is written to the FIFO at edge N+2 and is visible on res_* after edge N+2 when the FIFO is empty. Minimum latency is 2 cycles.
- Throughput: 1 request/cycle while the FIFO is not full.
- Handshake and stall:
  - S2 advances if it is empty, or the FIFO is not full, or a pop happens the same cycle.
  - S1 advances if S2 advances or S2 is empty.
  - ready_o = !S1.valid || S1 advances. ready_o is combinational from FIFO state and res_ready_i only.
- FIFO:
  - Push and pop in the same cycle when full is legal; count_o is unchanged.
  - Pop when empty is ignored.
  - Pointers wrap modulo DEPTH.
- flush_i (synchronous):
  - Clears S1, S2 and the FIFO next edge; count_o = 0.
  - A request presented with flush_i is dropped.
  - flush_i has priority over push/pop.
- Outputs are stable while res_valid_o && !res_ready_i.

Optional Feature:
- Macro: CHERI_BRANCH_STATS_EN.
- When defined, adds two outputs:
  - stat_resolved_o (32): counts FIFO pushes.
  - stat_mispredict_o (32): counts FIFO pushes with mispredict=1.
  - Both saturate at 2^32-1, clear on reset, and are unaffected by flush_i.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- JAL, pc=0x1000, imm=0x20, pred_taken=1, pred_target=0x1020 -> 2 cycles later: res_target=0x1020, res_link=0x1004, taken=1, mispredict=0, cause=0.
- BRANCH, cmp_res=0, pred_taken=1, pc=0x2000, compressed -> res_target=0x2002, taken=0, mispredict=1, cause=0. Same case with imm=0x3 -> still cause=0.
- CJALR, opa_tag=0, opa_sealed=1, opa_sentry=0 -> cause=5 (tag beats seal). With tag=1 -> cause=4. Sentry with imm=0, perm_x=1, in bounds -> cause=0.
- pc=0x3000, pcc_top=0x3000, CJALR with tag=0 -> cause=6 (PCC length has top priority).
- res_ready_i=0, 8 back-to-back requests with DEPTH=4 -> count_o reaches 4, ready_o drops after 6 accepts. Release ready -> all 6 drain in order of trans_id.
- FIFO holding 3 entries plus S1/S2 valid; assert flush_i 1 cycle -> next edge count_o=0, res_valid_o=0. Async reset mid-stream -> same within the reset.

Source files
------------

// File: rtl/cheri_branch_resolve_pipe.sv
// -----------------------------------------------------------------------------
// cheri_branch_resolve_pipe
//
// Pipelined CHERI branch/jump resolver. This block sits between the issue stage
// and frontend PC generation. Each accepted request flows through two register
// stages and then into a DEPTH-entry resolution FIFO:
//    S1 : computes the target (pc- or rs1-relative), the link value and taken.
//    S2 : computes the next fetch address, mispredict and the exception cause.
//    FIFO : holds resolutions until the frontend/scoreboard pops them.
//
// Ports
//    clk_i, rst_ni          clock, asynchronous active-low reset
//    flush_i                synchronous flush of S1, S2 and the FIFO
//    valid_i / ready_o      request handshake
//    op_i                   0=BRANCH 1=JAL 2=JALR 3=CJALR
//    trans_id_i, pc_i, imm_i, is_compressed_i, cmp_res_i   request fields
//    pcc_base_i, pcc_top_i  current PCC bounds (top exclusive)
//    opa_*                  rs1 address and capability metadata
//    pred_taken_i, pred_target_i   frontend prediction
//    res_valid_o / res_ready_i     resolution handshake (FIFO head)
//    res_*                  head entry; all zero while the FIFO is empty
//    count_o                FIFO occupancy
//
// Optional feature (macro CHERI_BRANCH_STATS_EN):
//    stat_resolved_o, stat_mispredict_o  saturating 32-bit push counters.
//    They clear on reset only; flush_i does not touch them.
// -----------------------------------------------------------------------------
module cheri_branch_resolve_pipe #(
   parameter int VLEN          = 39,
   parameter int DEPTH         = 4,
   parameter int TRANS_ID_BITS = 3,
   parameter int RVC           = 1
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     flush_i,
   input  logic                     valid_i,
   output logic                     ready_o,
   input  logic [1:0]               op_i,
   input  logic [TRANS_ID_BITS-1:0] trans_id_i,
   input  logic [VLEN-1:0]          pc_i,
   input  logic [VLEN-1:0]          pcc_base_i,
   input  logic [VLEN:0]            pcc_top_i,
   input  logic                     is_compressed_i,
   input  logic [VLEN-1:0]          imm_i,
   input  logic                     cmp_res_i,
   input  logic [VLEN-1:0]          opa_addr_i,
   input  logic [VLEN-1:0]          opa_base_i,
   input  logic [VLEN:0]            opa_top_i,
   input  logic                     opa_tag_i,
   input  logic                     opa_perm_x_i,
   input  logic                     opa_sealed_i,
   input  logic                     opa_sentry_i,
   input  logic                     pred_taken_i,
   input  logic [VLEN-1:0]          pred_target_i,
   output logic                     res_valid_o,
   input  logic                     res_ready_i,
   output logic [TRANS_ID_BITS-1:0] res_trans_id_o,
   output logic [VLEN-1:0]          res_pc_o,
   output logic [VLEN-1:0]          res_target_o,
   output logic [VLEN-1:0]          res_link_o,
   output logic                     res_taken_o,
   output logic                     res_mispredict_o,
   output logic [2:0]               res_ex_cause_o,
   output logic [$clog2(DEPTH):0]   count_o
`ifdef CHERI_BRANCH_STATS_EN
   ,
   output logic [31:0]              stat_resolved_o,
   output logic [31:0]              stat_mispredict_o
`endif
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [1:0] OP_BRANCH = 2'd0;
   localparam logic [1:0] OP_CJALR  = 2'd3;
   localparam logic [VLEN:0] TWO_EXT = (VLEN+1)'(2);

   typedef struct packed {
      logic [1:0]               op;
      logic [TRANS_ID_BITS-1:0] trans_id;
      logic [VLEN-1:0]          pc;
      logic [VLEN-1:0]          pcc_base;
      logic [VLEN:0]            pcc_top;
      logic                     imm_nz;
      logic [VLEN-1:0]          target;
      logic [VLEN-1:0]          link;
      logic                     taken;
      logic [VLEN-1:0]          opa_base;
      logic [VLEN:0]            opa_top;
      logic                     opa_tag;
      logic                     opa_perm_x;
      logic                     opa_sealed;
      logic                     opa_sentry;
      logic                     pred_taken;
      logic [VLEN-1:0]          pred_target;
   } s1_t;

   typedef struct packed {
      logic [TRANS_ID_BITS-1:0] trans_id;
      logic [VLEN-1:0]          pc;
      logic [VLEN-1:0]          target;
      logic [VLEN-1:0]          link;
      logic                     taken;
      logic                     mispredict;
      logic [2:0]               cause;
   } res_t;

   logic             s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
   s1_t              s1_q, s1_d, s1_calc;
   res_t             s2_q, s2_d, s2_calc, head;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   res_t             mem_q [DEPTH];

   logic fifo_full, pop, push, s2_adv, accept;
   logic [VLEN-1:0] s1_base;
   logic            is_cjalr, pcc_viol, len_viol, misal;

   // ---------------- handshake ----------------
   always_comb begin
      fifo_full = (count_q == CNT_W'(DEPTH));
      pop       = (count_q != '0) && res_ready_i;
      // A full FIFO still accepts S2 when the head is popped the same cycle.
      s2_adv    = !s2_valid_q || !fifo_full || pop;
      push      = s2_valid_q && s2_adv;
      // S2 empty already implies s2_adv, so S1 advances exactly when S2 does.
      ready_o   = !s1_valid_q || s2_adv;
      accept    = valid_i && ready_o && !flush_i;
   end

   // ---------------- S1 datapath ----------------
   always_comb begin
      // op_i[1] selects the register-relative jumps (JALR, CJALR).
      s1_base             = op_i[1] ? opa_addr_i : pc_i;
      s1_calc             = '0;
      s1_calc.op          = op_i;
      s1_calc.trans_id    = trans_id_i;
      s1_calc.pc          = pc_i;
      s1_calc.pcc_base    = pcc_base_i;
      s1_calc.pcc_top     = pcc_top_i;
      s1_calc.imm_nz      = (imm_i != '0);
      s1_calc.target      = s1_base + imm_i;
      if (op_i[1]) begin
         s1_calc.target[0] = 1'b0;
      end
      s1_calc.link        = pc_i + (is_compressed_i ? VLEN'(2) : VLEN'(4));
      s1_calc.taken       = (op_i == OP_BRANCH) ? cmp_res_i : 1'b1;
      s1_calc.opa_base    = opa_base_i;
      s1_calc.opa_top     = opa_top_i;
      s1_calc.opa_tag     = opa_tag_i;
      s1_calc.opa_perm_x  = opa_perm_x_i;
      s1_calc.opa_sealed  = opa_sealed_i;
      s1_calc.opa_sentry  = opa_sentry_i;
      s1_calc.pred_taken  = pred_taken_i;
      s1_calc.pred_target = pred_target_i;
   end

   // ---------------- S2 datapath ----------------
   always_comb begin
      is_cjalr = (s1_q.op == OP_CJALR);
      pcc_viol = ({1'b0, s1_q.pc} < {1'b0, s1_q.pcc_base}) ||
                 ({1'b0, s1_q.pc} >= s1_q.pcc_top);
      // Bounds in VLEN+1 bits so target+2 cannot wrap.
      len_viol = is_cjalr && s1_q.taken &&
                 (({1'b0, s1_q.target} < {1'b0, s1_q.opa_base}) ||
                  (({1'b0, s1_q.target} + TWO_EXT) > s1_q.opa_top));
      misal    = s1_q.taken && (s1_q.target[0] || ((RVC == 0) && s1_q.target[1]));

      s2_calc          = '0;
      s2_calc.trans_id = s1_q.trans_id;
      s2_calc.pc       = s1_q.pc;
      s2_calc.target   = s1_q.taken ? s1_q.target : s1_q.link;
      s2_calc.link     = s1_q.link;
      s2_calc.taken    = s1_q.taken;

      if (pcc_viol)                                                   s2_calc.cause = 3'd6;
      else if (is_cjalr && !s1_q.opa_tag)                             s2_calc.cause = 3'd5;
      else if (is_cjalr && s1_q.opa_sealed &&
               (!s1_q.opa_sentry || s1_q.imm_nz))                     s2_calc.cause = 3'd4;
      else if (is_cjalr && !s1_q.opa_perm_x)                          s2_calc.cause = 3'd3;
      else if (len_viol)                                              s2_calc.cause = 3'd2;
      else if (misal)                                                 s2_calc.cause = 3'd1;
      else                                                            s2_calc.cause = 3'd0;

      // An excepting entry redirects through the trap path, not as a mispredict.
      if (s2_calc.cause != 3'd0)
         s2_calc.mispredict = 1'b0;
      else if (s1_q.op == OP_BRANCH)
         s2_calc.mispredict = (s1_q.taken != s1_q.pred_taken);
      else
         s2_calc.mispredict = !s1_q.pred_taken || (s1_q.target != s1_q.pred_target);
   end

   // ---------------- next-state ----------------
   always_comb begin
      s1_valid_d = flush_i ? 1'b0 : (ready_o ? valid_i : s1_valid_q);
      s1_d       = accept ? s1_calc : s1_q;
      s2_valid_d = flush_i ? 1'b0 : (s2_adv ? s1_valid_q : s2_valid_q);
      s2_d       = (s2_adv && s1_valid_q && !flush_i) ? s2_calc : s2_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         if (push && !pop)      count_d = count_q + CNT_W'(1);
         else if (pop && !push) count_d = count_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         s1_valid_q <= 1'b0;
         s2_valid_q <= 1'b0;
         s1_q       <= '0;
         s2_q       <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s2_valid_q <= s2_valid_d;
         s1_q       <= s1_d;
         s2_q       <= s2_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
      end
   end

   // Storage needs no reset: the head is masked to zero while the FIFO is empty.
   always_ff @(posedge clk_i) begin
      if (push && !flush_i) begin
         mem_q[wr_ptr_q] <= s2_q;
      end
   end

   assign res_valid_o      = (count_q != '0);
   assign head             = res_valid_o ? mem_q[rd_ptr_q] : '0;
   assign res_trans_id_o   = head.trans_id;
   assign res_pc_o         = head.pc;
   assign res_target_o     = head.target;
   assign res_link_o       = head.link;
   assign res_taken_o      = head.taken;
   assign res_mispredict_o = head.mispredict;
   assign res_ex_cause_o   = head.cause;
   assign count_o          = count_q;

`ifdef CHERI_BRANCH_STATS_EN
   logic [31:0] stat_res_q, stat_res_d, stat_mis_q, stat_mis_d;

   always_comb begin
      stat_res_d = stat_res_q;
      stat_mis_d = stat_mis_q;
      if (push && !flush_i && (stat_res_q != '1))
         stat_res_d = stat_res_q + 32'd1;
      if (push && !flush_i && s2_q.mispredict && (stat_mis_q != '1))
         stat_mis_d = stat_mis_q + 32'd1;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         stat_res_q <= '0;
         stat_mis_q <= '0;
      end else begin
         stat_res_q <= stat_res_d;
         stat_mis_q <= stat_mis_d;
      end
   end

   assign stat_resolved_o   = stat_res_q;
   assign stat_mispredict_o = stat_mis_q;
`endif

endmodule
